rvx_core_divider: RTL
=====================

// Module: rvx_core_divider
// PURPOSE
//   Iterative RV32M divide unit (DIV/DIVU/REM/REMU) beside the combinational ALU in the execute stage.
//   Accepts operands on a start pulse, runs one restoring-division step per cycle, then returns a
//   32-bit result with a one-cycle valid pulse. Pipeline control stalls on div_busy_s2 until valid.
// PARAMETERS
//   (none) -- fixed XLEN 32, one quotient bit per cycle
// PORTS
//   clock               in   1   core clock; all state updates on rising edge
//   reset_n             in   1   synchronous, active-low reset
//   div_start_s2        in   1   start request; accepted only when div_busy_s2 == 0
//   div_operation_s2    in   3   funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_data_s2         in   32  dividend
//   rs2_data_s2         in   32  divisor
//   div_flush_s2        in   1   abort current operation (pipeline flush/trap)
//   div_busy_s2         out  1   high from accept edge until the edge after the valid cycle
//   div_valid_s2        out  1   one-cycle pulse: div_result_s2 is valid
//   div_result_s2       out  32  quotient or remainder; held until next accepted start
// BEHAVIOUR
//   - Reset (reset_n == 0 at an edge): state IDLE, counter 0, div_busy_s2 0, div_valid_s2 0,
//     div_result_s2 0. Reset beats any in-flight operation, start and flush.
//   - States: IDLE -> (start) BUSY or DONE; BUSY -> (32 steps) DONE; DONE -> IDLE.
//   - Accept: div_start_s2 && IDLE at edge E0. Operand magnitudes, sign of quotient
//     (rs1[31]^rs2[31], signed ops only), sign of remainder (rs1[31], signed ops only) and op latched.
//   - Normal path: BUSY for 32 cycles (edges E1..E32), one step each: shift {rem,quot} left 1,
//     trial-subtract divisor magnitude from 33-bit partial remainder; keep if non-negative, set quot bit.
//     DONE entered at E32; div_valid_s2 high for that single cycle; IDLE at E33. Latency 33 cycles.
//   - Sign fix-up applied when entering DONE: negate quotient/remainder per latched signs (two's
//     complement, 32-bit wrap).
//   - Fast paths (DONE entered at E0, valid in the cycle after E0, 1-cycle latency):
//     divisor == 0: quotient 0xFFFFFFFF (all ops), remainder = rs1 unmodified.
//     signed overflow (DIV/REM, rs1 0x80000000, rs2 0xFFFFFFFF): quotient 0x80000000, remainder 0.
//   - div_busy_s2 = (state != IDLE); asserted combinationally from state, so high in DONE cycle too.
//   - Start while BUSY or DONE: ignored, no effect on latched operands or result.
//   - Flush: div_flush_s2 at any edge in BUSY/DONE -> IDLE, no valid pulse, result unchanged.
//     Flush and start together in IDLE: flush wins, start ignored.
//   - div_result_s2 register updated only on the DONE-entry edge; div_valid_s2 never high two cycles
//     in a row.
//   - Undefined funct3 (0xx): treated as DIVU; the decoder never issues it.
// STRUCTURE
//   - Add RISCV_FUNCT3_DIV/DIVU/REM/REMU and state encodings (IDLE/BUSY/DONE) to rvx_constants.vh.
//   - One natural sub-module: rvx_core_divider_step (combinational shift/trial-subtract of one bit:
//     33-bit partial remainder, 32-bit quotient, divisor in; next values out). Top keeps FSM, counter,
//     operand/sign latches and sign fix-up.
// TESTING
//   - DIVU 100/7: start at E0 -> busy 33 cycles, valid once at cycle 33, result 0x0000000E.
//   - REM -100/7 (0xFFFFFF9C, 7) -> result 0xFFFFFFFE; DIV same operands -> 0xFFFFFFF2.
//   - DIVU 5/0 -> valid in cycle after start, 0xFFFFFFFF; REMU 5/0 -> 0x00000005.
//   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at 1-cycle latency; REM same -> 0x00000000.
//   - Flush 10 cycles into DIVU: no valid ever, busy low next cycle, new start accepted, correct result.
//   - Start pulses while busy ignored; reset_n low mid-operation -> all outputs 0 next cycle.
//   - Random 10k ops vs. reference model incl. INT_MIN, -1, 0, 1 corners; check valid pulse width 1.

Source files
------------

// File: rtl/rvx_core_divider_pkg.sv
// rvx_core_divider_pkg: funct3 encodings, FSM states and helpers for the RV32M divider
package rvx_core_divider_pkg;
  localparam logic [2:0] RISCV_FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] RISCV_FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] RISCV_FUNCT3_REM  = 3'b110;
  localparam logic [2:0] RISCV_FUNCT3_REMU = 3'b111;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/rvx_core_divider_step.sv
// rvx_core_divider_step: one restoring-division step (shift, trial-subtract, keep or restore)
module rvx_core_divider_step
  import rvx_core_divider_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quot_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  always_comb begin
    shifted = {rem_i[XLEN-1:0], quot_i[XLEN-1]};
    trial   = shifted - {1'b0, dvsr_i};
    rem_o   = trial[XLEN] ? shifted : trial;
    quot_o  = {quot_i[XLEN-2:0], ~trial[XLEN]};
  end
endmodule

// File: rtl/rvx_core_divider.sv
// rvx_core_divider: iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle
module rvx_core_divider
  import rvx_core_divider_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            div_start_s2,
  input  logic [2:0]      div_operation_s2,
  input  logic [XLEN-1:0] rs1_data_s2,
  input  logic [XLEN-1:0] rs2_data_s2,
  input  logic            div_flush_s2,
  output logic            div_busy_s2,
  output logic            div_valid_s2,
  output logic [XLEN-1:0] div_result_s2
);
  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d, rem_n;
  logic [XLEN-1:0] quot_q, quot_d, quot_n;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d, is_rem_q, is_rem_d;
  logic            valid_q, valid_d;
  logic            accept, is_signed, is_rem, div_zero, ovf;
  rvx_core_divider_step u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_n),
    .quot_o (quot_n)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    is_rem_d  = is_rem_q;
    valid_d   = 1'b0;
    accept    = state_q == DIV_IDLE && div_start_s2 && !div_flush_s2;
    is_signed = div_operation_s2[2] & ~div_operation_s2[0];
    is_rem    = div_operation_s2[2] & div_operation_s2[1];
    div_zero  = rs2_data_s2 == '0;
    ovf       = is_signed && rs1_data_s2 == 32'h8000_0000 && rs2_data_s2 == '1;
    if (div_flush_s2 && state_q != DIV_IDLE) begin
      state_d = DIV_IDLE;
    end else if (accept) begin
      if (div_zero || ovf) begin
        state_d  = DIV_DONE;
        valid_d  = 1'b1;
        result_d = div_zero ? (is_rem ? rs1_data_s2 : '1) : (is_rem ? '0 : 32'h8000_0000);
      end else begin
        state_d  = DIV_BUSY;
        cnt_d    = '0;
        rem_d    = '0;
        quot_d   = neg_if(rs1_data_s2, is_signed & rs1_data_s2[XLEN-1]);
        dvsr_d   = neg_if(rs2_data_s2, is_signed & rs2_data_s2[XLEN-1]);
        neg_q_d  = is_signed & (rs1_data_s2[XLEN-1] ^ rs2_data_s2[XLEN-1]);
        neg_r_d  = is_signed & rs1_data_s2[XLEN-1];
        is_rem_d = is_rem;
      end
    end else if (state_q == DIV_BUSY) begin
      rem_d  = rem_n;
      quot_d = quot_n;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d  = DIV_DONE;
        valid_d  = 1'b1;
        result_d = is_rem_q ? neg_if(rem_n[XLEN-1:0], neg_r_q) : neg_if(quot_n, neg_q_q);
      end
    end else if (state_q == DIV_DONE) begin
      state_d = DIV_IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      is_rem_q <= is_rem_d;
      valid_q  <= valid_d;
    end
  end
  assign div_busy_s2   = state_q != DIV_IDLE;
  assign div_valid_s2  = valid_q;
  assign div_result_s2 = result_q;
endmodule
